// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the dmem arbiter: state encoding, width codes, data width.
package dmem_arbiter_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN0  = 2'd1,
    ST_OWN1  = 2'd2,
    ST_ABORT = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    W_BYTE = 2'b00,
    W_HALF = 2'b01,
    W_WORD = 2'b10
  } mem_width_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Two requester ports plus the shared dmem bus.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface dmem_arbiter_if;
    import dmem_arbiter_pkg::*;

    logic              m0_req,   m1_req;
    logic              m0_cmd,   m1_cmd;
    logic [1:0]        m0_width, m1_width;
    logic [DATA_W-1:0] m0_addr,  m1_addr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic              m0_gnt,   m1_gnt;
    logic              m0_resp,  m1_resp;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic              m0_err,   m1_err;

    logic              dmem_req;
    logic              dmem_cmd;
    logic [1:0]        dmem_width;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_resp;
    logic              dmem_err;

    modport slave (
        input  m0_req, m0_cmd, m0_width, m0_addr, m0_wdata,
        input  m1_req, m1_cmd, m1_width, m1_addr, m1_wdata,
        output m0_gnt, m0_resp, m0_rdata, m0_err,
        output m1_gnt, m1_resp, m1_rdata, m1_err,
        output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_resp, dmem_err
    );

    modport master (
        output m0_req, m0_cmd, m0_width, m0_addr, m0_wdata,
        output m1_req, m1_cmd, m1_width, m1_addr, m1_wdata,
        input  m0_gnt, m0_resp, m0_rdata, m0_err,
        input  m1_gnt, m1_resp, m1_rdata, m1_err,
        input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_resp, dmem_err
    );

endinterface

// File: rtl/dmem_arbiter_arb_rr2.sv
// Two-way round-robin grant: a lone requester wins; on contention the port not served last wins.
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       en,
    input  logic       last,
    output logic [1:0] gnt
);

    // One-hot grant, only while the bus can take a new transaction.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single dmem bus between port 0 (membuf) and port 1 (aux master).
// One transaction outstanding; a new one may issue in the cycle the current response returns.
// Optional response watchdog with ABORT state: define DMEM_ARB_TIMEOUT_EN (limit TO_CYCLES).
module dmem_arbiter
    import dmem_arbiter_pkg::*;
`ifdef DMEM_ARB_TIMEOUT_EN
#(
    parameter int TO_CYCLES = 64
)
`endif
(
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus,
    output logic          busy
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic [1:0] gnt;
    logic       own0, own1, can_issue, to_fire;

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TO_CYCLES - 1);
    logic [7:0] cnt_q, cnt_d;

    // Watchdog fires on the last allowed owned cycle that still has no response.
    assign to_fire = (own0 | own1) & ~bus.dmem_resp & (cnt_q == TO_LAST);
`else
    assign to_fire = 1'b0;
`endif

    assign own0      = (state_q == ST_OWN0);
    assign own1      = (state_q == ST_OWN1);
    assign can_issue = (state_q == ST_IDLE) | ((own0 | own1) & bus.dmem_resp);

    arb_rr2 u_rr (
        .req  ({bus.m1_req, bus.m0_req}),
        .en   (can_issue & ~rst),
        .last (last_q),
        .gnt  (gnt)
    );

    assign bus.m0_gnt = gnt[0];
    assign bus.m1_gnt = gnt[1];
    assign busy       = ~rst & (state_q != ST_IDLE);

    // Drive the bus from the granted master, zero when nothing is granted.
    always_comb begin
        bus.dmem_req   = |gnt;
        bus.dmem_cmd   = 1'b0;
        bus.dmem_width = 2'b00;
        bus.dmem_addr  = '0;
        bus.dmem_wdata = '0;
        if (gnt[0]) begin
            bus.dmem_cmd   = bus.m0_cmd;
            bus.dmem_width = bus.m0_width;
            bus.dmem_addr  = bus.m0_addr;
            bus.dmem_wdata = bus.m0_wdata;
        end else if (gnt[1]) begin
            bus.dmem_cmd   = bus.m1_cmd;
            bus.dmem_width = bus.m1_width;
            bus.dmem_addr  = bus.m1_addr;
            bus.dmem_wdata = bus.m1_wdata;
        end
    end

    // Route the response (or a watchdog error) to the owner; responses seen in IDLE/ABORT are dropped.
    always_comb begin
        bus.m0_resp  = 1'b0;
        bus.m0_err   = 1'b0;
        bus.m0_rdata = '0;
        bus.m1_resp  = 1'b0;
        bus.m1_err   = 1'b0;
        bus.m1_rdata = '0;
        if (!rst) begin
            bus.m0_resp  = own0 & (bus.dmem_resp | to_fire);
            bus.m0_err   = own0 & (bus.dmem_resp ? bus.dmem_err : to_fire);
            bus.m0_rdata = (own0 & bus.dmem_resp) ? bus.dmem_rdata : '0;
            bus.m1_resp  = own1 & (bus.dmem_resp | to_fire);
            bus.m1_err   = own1 & (bus.dmem_resp ? bus.dmem_err : to_fire);
            bus.m1_rdata = (own1 & bus.dmem_resp) ? bus.dmem_rdata : '0;
        end
    end

    // Next state, round-robin pointer and watchdog counter.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
`ifdef DMEM_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        if (gnt[0]) begin
            state_d = ST_OWN0;
            last_d  = 1'b0;
        end else if (gnt[1]) begin
            state_d = ST_OWN1;
            last_d  = 1'b1;
        end else begin
            case (state_q)
                ST_OWN0, ST_OWN1: begin
                    if (bus.dmem_resp)
                        state_d = ST_IDLE;
                    else if (to_fire)
                        state_d = ST_ABORT;
                end
`ifdef DMEM_ARB_TIMEOUT_EN
                ST_ABORT: begin
                    if (bus.dmem_resp || (cnt_q == TO_LAST))
                        state_d = ST_IDLE;
                end
`endif
                default: ;
            endcase
        end
`ifdef DMEM_ARB_TIMEOUT_EN
        if ((|gnt) || to_fire)
            cnt_d = 8'd0;
        else if ((own0 | own1) & ~bus.dmem_resp)
            cnt_d = cnt_q + 8'd1;
        else if (state_q == ST_ABORT)
            cnt_d = cnt_q + 8'd1;
`endif
    end

    // State registers with synchronous reset; port 0 wins the first contention.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
`ifdef DMEM_ARB_TIMEOUT_EN
            cnt_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
`ifdef DMEM_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then randomized
// traffic; a cycle-level reference model checks every output on every falling edge.
`timescale 1ns/1ps
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int TO = 8;
`endif

    logic clk;
    logic rst;
    logic busy;
    int   n_checks = 0;
    int   n_err    = 0;

    dmem_arbiter_if bus ();

`ifdef DMEM_ARB_TIMEOUT_EN
    dmem_arbiter #(.TO_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus), .busy(busy));
`else
    dmem_arbiter dut (.clk(clk), .rst(rst), .bus(bus), .busy(busy));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // owner: -1 = nothing outstanding, 0/1 = port owning the bus, 2 = aborted transaction.
    int owner = -1;
    int served_last = 1;
    int cyc = 0;
    int t_grant = 0;
    int t_abort = 0;

    always @(negedge clk) begin : model
        logic [1:0]  e_gnt, e_resp, e_err;
        logic [31:0] e_rd0, e_rd1, e_addr, e_wd;
        logic        e_cmd, e_busy;
        logic [1:0]  e_wid;
        bit          free, tout;
        int          win;

        e_gnt = 0; e_resp = 0; e_err = 0; e_rd0 = 0; e_rd1 = 0;
        e_addr = 0; e_wd = 0; e_cmd = 0; e_wid = 0; e_busy = 0;
        win = -1; tout = 0;
        if (rst) begin
            owner = -1;
            served_last = 1;
        end else begin
            e_busy = (owner != -1);
            if (owner == 0 || owner == 1) begin
                if (bus.dmem_resp) begin
                    e_resp[owner] = 1'b1;
                    e_err[owner]  = bus.dmem_err;
                    if (owner == 0) e_rd0 = bus.dmem_rdata; else e_rd1 = bus.dmem_rdata;
                end
`ifdef DMEM_ARB_TIMEOUT_EN
                else if (cyc - t_grant == TO) begin
                    tout = 1;
                    e_resp[owner] = 1'b1;
                    e_err[owner]  = 1'b1;
                end
`endif
            end
            free = (owner == -1) || ((owner == 0 || owner == 1) && bus.dmem_resp);
            if (free) begin
                if (bus.m0_req && bus.m1_req) win = (served_last == 1) ? 0 : 1;
                else if (bus.m0_req) win = 0;
                else if (bus.m1_req) win = 1;
            end
            if (win == 0) begin
                e_gnt[0] = 1; e_cmd = bus.m0_cmd; e_wid = bus.m0_width;
                e_addr = bus.m0_addr; e_wd = bus.m0_wdata;
            end else if (win == 1) begin
                e_gnt[1] = 1; e_cmd = bus.m1_cmd; e_wid = bus.m1_width;
                e_addr = bus.m1_addr; e_wd = bus.m1_wdata;
            end
            if (win >= 0) begin
                owner = win; served_last = win; t_grant = cyc;
            end else if ((owner == 0 || owner == 1) && bus.dmem_resp) begin
                owner = -1;
            end else if (tout) begin
                owner = 2; t_abort = cyc + 1;
            end
`ifdef DMEM_ARB_TIMEOUT_EN
            else if (owner == 2 && (bus.dmem_resp || (cyc - t_abort == TO - 1))) begin
                owner = -1;
            end
`endif
        end
        check("m0_gnt", 32'(bus.m0_gnt), 32'(e_gnt[0]));
        check("m1_gnt", 32'(bus.m1_gnt), 32'(e_gnt[1]));
        check("m0_resp", 32'(bus.m0_resp), 32'(e_resp[0]));
        check("m1_resp", 32'(bus.m1_resp), 32'(e_resp[1]));
        check("m0_err", 32'(bus.m0_err), 32'(e_err[0]));
        check("m1_err", 32'(bus.m1_err), 32'(e_err[1]));
        check("m0_rdata", bus.m0_rdata, e_rd0);
        check("m1_rdata", bus.m1_rdata, e_rd1);
        check("dmem_req", 32'(bus.dmem_req), 32'(|e_gnt));
        check("dmem_cmd", 32'(bus.dmem_cmd), 32'(e_cmd));
        check("dmem_width", 32'(bus.dmem_width), 32'(e_wid));
        check("dmem_addr", bus.dmem_addr, e_addr);
        check("dmem_wdata", bus.dmem_wdata, e_wd);
        check("busy", 32'(busy), 32'(e_busy));
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic sample();
        @(negedge clk); #1;
    endtask

    task automatic clear_inputs();
        bus.m0_req = 0; bus.m0_cmd = 0; bus.m0_width = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
        bus.m1_req = 0; bus.m1_cmd = 0; bus.m1_width = 0; bus.m1_addr = 0; bus.m1_wdata = 0;
        bus.dmem_rdata = 0; bus.dmem_resp = 0; bus.dmem_err = 0;
    endtask

    task automatic do_reset();
        step(); rst = 1; clear_inputs();
        step(); rst = 0;
    endtask

    task automatic rand_req(input int n);
        if (n == 0) begin
            bus.m0_req = 1; bus.m0_cmd = 1'($urandom_range(0, 1)); bus.m0_width = 2'($urandom_range(0, 2));
            bus.m0_addr = $urandom; bus.m0_wdata = $urandom;
        end else begin
            bus.m1_req = 1; bus.m1_cmd = 1'($urandom_range(0, 1)); bus.m1_width = 2'($urandom_range(0, 2));
            bus.m1_addr = $urandom; bus.m1_wdata = $urandom;
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin : main
        bit pend;
        int wt;
        logic sg0, sg1, sreq;
        logic [1:0] g;

        clear_inputs();
        rst = 1;
        bus.m0_req = 1; bus.m0_addr = 32'h100; bus.m0_width = 2'b10; bus.m0_cmd = 0;
        bus.dmem_resp = 1;
        sample();
        check("rst_m0_gnt", 32'(bus.m0_gnt), 0);
        check("rst_dmem_req", 32'(bus.dmem_req), 0);
        check("rst_busy", 32'(busy), 0);

        // Lone m0 load to 0x100, response three cycles later.
        step(); rst = 0; bus.dmem_resp = 0;
        sample();
        check("ld_m0_gnt", 32'(bus.m0_gnt), 1);
        check("ld_dmem_req", 32'(bus.dmem_req), 1);
        check("ld_dmem_addr", bus.dmem_addr, 32'h100);
        step(); bus.m0_req = 0;
        step();
        step(); bus.dmem_resp = 1; bus.dmem_rdata = 32'hDEADBEEF;
        sample();
        check("ld_m0_resp", 32'(bus.m0_resp), 1);
        check("ld_m0_rdata", bus.m0_rdata, 32'hDEADBEEF);
        check("ld_m1_resp", 32'(bus.m1_resp), 0);

        // Contention from reset: strict alternation, each response cycle regrants.
        do_reset();
        bus.m0_req = 1; bus.m0_addr = 32'h300;
        bus.m1_req = 1; bus.m1_addr = 32'h400;
        sample();
        check("rr_first_gnt", 32'({bus.m1_gnt, bus.m0_gnt}), 32'h1);
        for (int r = 1; r <= 8; r++) begin
            step(); bus.dmem_resp = 1; bus.dmem_rdata = 32'(r);
            sample();
            g = {bus.m1_gnt, bus.m0_gnt};
            check("rr_gnt", 32'(g), (r % 2 == 1) ? 32'h2 : 32'h1);
            check("rr_prev_resp", 32'({bus.m1_resp, bus.m0_resp}), (r % 2 == 1) ? 32'h1 : 32'h2);
        end
        step(); bus.m0_req = 0; bus.m1_req = 0; bus.dmem_resp = 1;
        sample();
        check("rr_tail_busy", 32'(busy), 1);
        step(); bus.dmem_resp = 0;
        sample();
        check("rr_idle_busy", 32'(busy), 0);

        // Back-to-back handover from m0 to m1, then m1 store with error.
        step(); bus.m0_req = 1; bus.m0_addr = 32'h500; bus.m0_cmd = 0;
        sample();
        check("b2b_m0_gnt", 32'(bus.m0_gnt), 1);
        step(); bus.m0_req = 0;
        bus.m1_req = 1; bus.m1_cmd = 1; bus.m1_width = 2'b01; bus.m1_addr = 32'h202; bus.m1_wdata = 32'hCAFE0001;
        sample();
        check("b2b_m1_wait", 32'(bus.m1_gnt), 0);
        step(); bus.dmem_resp = 1; bus.dmem_rdata = 32'h11;
        sample();
        check("b2b_m0_resp", 32'(bus.m0_resp), 1);
        check("b2b_m1_gnt", 32'(bus.m1_gnt), 1);
        check("b2b_dmem_req", 32'(bus.dmem_req), 1);
        check("st_addr", bus.dmem_addr, 32'h202);
        check("st_width", 32'(bus.dmem_width), 32'h1);
        step(); bus.m1_req = 0; bus.dmem_resp = 1; bus.dmem_err = 1; bus.dmem_rdata = 32'h22;
        sample();
        check("st_m1_resp", 32'(bus.m1_resp), 1);
        check("st_m1_err", 32'(bus.m1_err), 1);
        check("st_m0_quiet", 32'({bus.m0_resp, bus.m0_err}), 0);
        check("st_m0_rdata", bus.m0_rdata, 0);

        // Spurious response in IDLE.
        step(); bus.dmem_err = 0; bus.dmem_resp = 1;
        sample();
        check("spur_resp", 32'({bus.m1_resp, bus.m0_resp}), 0);

        // Reset while m1 owns the bus; the late response is dropped.
        step(); bus.dmem_resp = 0; bus.m1_req = 1;
        sample();
        check("rst1_m1_gnt", 32'(bus.m1_gnt), 1);
        step(); bus.m1_req = 0; rst = 1;
        sample();
        check("rst1_busy_in_rst", 32'(busy), 0);
        step(); rst = 0; bus.dmem_resp = 1;
        sample();
        check("rst1_busy_after", 32'(busy), 0);
        check("rst1_late_resp", 32'(bus.m1_resp), 0);
        step(); bus.dmem_resp = 0;

`ifdef DMEM_ARB_TIMEOUT_EN
        // Watchdog: no response, timeout at grant+8, ABORT until the late response at grant+12.
        do_reset();
        bus.dmem_rdata = 32'hBAD0BAD0;
        bus.m0_req = 1; bus.m0_addr = 32'h700;
        sample();
        check("to_m0_gnt", 32'(bus.m0_gnt), 1);
        for (int k = 1; k <= 7; k++) begin
            step(); bus.m0_req = 0;
            sample();
            check("to_wait_resp", 32'(bus.m0_resp), 0);
        end
        step(); bus.m1_req = 1; bus.m1_addr = 32'h800;
        sample();
        check("to_m0_resp", 32'(bus.m0_resp), 1);
        check("to_m0_err", 32'(bus.m0_err), 1);
        check("to_m0_rdata", bus.m0_rdata, 0);
        check("to_m1_blocked", 32'(bus.m1_gnt), 0);
        for (int k = 9; k <= 11; k++) begin
            step();
            sample();
            check("abort_m1_blocked", 32'(bus.m1_gnt), 0);
            check("abort_busy", 32'(busy), 1);
        end
        step(); bus.dmem_resp = 1;
        sample();
        check("abort_late_drop", 32'({bus.m1_resp, bus.m0_resp}), 0);
        check("abort_late_gnt", 32'(bus.m1_gnt), 0);
        step(); bus.dmem_resp = 0;
        sample();
        check("abort_exit_gnt", 32'(bus.m1_gnt), 1);
        step(); bus.m1_req = 0; bus.dmem_resp = 1;
        step(); bus.dmem_resp = 0;
`endif

        // Randomized traffic: masters hold requests until granted, responder answers 1..4 cycles after issue.
        do_reset();
        pend = 0;
        wt = 0;
        for (int i = 0; i < 3000; i++) begin
            sample();
            sg0 = bus.m0_gnt; sg1 = bus.m1_gnt; sreq = bus.dmem_req;
            step();
            rst = ($urandom_range(0, 39) == 0);
            if (sg0) bus.m0_req = 0;
            if (sg1) bus.m1_req = 0;
            if (!bus.m0_req && $urandom_range(0, 2) == 0) rand_req(0);
            if (!bus.m1_req && $urandom_range(0, 2) == 0) rand_req(1);
            if (sreq) begin
                pend = 1;
                wt = $urandom_range(0, 3);
            end
            bus.dmem_rdata = $urandom;
            bus.dmem_err = ($urandom_range(0, 3) == 0);
            if (pend && wt == 0) begin
                bus.dmem_resp = 1;
                pend = 0;
            end else begin
                if (pend) wt--;
                bus.dmem_resp = !pend && ($urandom_range(0, 15) == 0);
            end
        end
        sample();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
